// File: rtl/i2c_angle_target.sv
// I2C target emulating a 12-bit magnetic angle sensor (read-only register map).
// Define I2C_TARGET_CLK_STRETCH_EN to stretch SCL after a read address ACK.
module i2c_angle_target #(
  parameter logic [6:0]  DEV_ADDR       = 7'h36,
  parameter int unsigned FILTER_CYCLES  = 3,
  parameter int unsigned STRETCH_CYCLES = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        scl_in,
  input  logic        sda_in,
  output logic        sda_oe,
  output logic        scl_oe,
  input  logic [11:0] angle,
  output logic        busy,
  output logic        xfer_done,
  output logic [7:0]  reg_ptr
);

  localparam int unsigned FW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WR_PTR,
    ST_PTR_ACK,
    ST_WR_DATA,
    ST_DATA_ACK,
    ST_RD_BYTE,
    ST_RD_ACK,
    ST_WAIT_STOP
`ifdef I2C_TARGET_CLK_STRETCH_EN
    , ST_STRETCH
`endif
  } state_t;

  function automatic logic [7:0] reg_value(input logic [7:0] ptr, input logic [11:0] snap);
    case (ptr)
      8'h0B:        reg_value = 8'h20;
      8'h0C, 8'h0E: reg_value = {4'h0, snap[11:8]};
      8'h0D, 8'h0F: reg_value = snap[7:0];
      default:      reg_value = 8'h00;
    endcase
  endfunction

  // index 0 = scl, index 1 = sda
  logic [1:0]         sync1_q, sync2_q, filt_q, filt_d, prev_q;
  logic [1:0][FW-1:0] fcnt_q, fcnt_d;

  state_t      state_q, state_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  rx_q, rx_d, tx_q, tx_d, ptr_q, ptr_d;
  logic [11:0] snap_q, snap_d;
  logic        rw_q, rw_d, busy_q, busy_d, done_q, done_d;
  logic        sda_oe_q, sda_oe_d, fall_dly_q;
  logic        scl_rise, scl_fall, start_det, stop_det, want_drive;

`ifdef I2C_TARGET_CLK_STRETCH_EN
  localparam int unsigned SW = $clog2(STRETCH_CYCLES + 1);
  logic          scl_oe_q, scl_oe_d;
  logic [SW-1:0] str_cnt_q, str_cnt_d;
  logic [7:0]    first_byte;
  assign first_byte = reg_value(ptr_q, angle);
`endif

  always_comb begin
    filt_d = filt_q;
    fcnt_d = fcnt_q;
    for (int unsigned i = 0; i < 2; i++) begin
      if (sync2_q[i] == filt_q[i]) begin
        fcnt_d[i] = '0;
      end else if (fcnt_q[i] == FW'(FILTER_CYCLES - 1)) begin
        filt_d[i] = sync2_q[i];
        fcnt_d[i] = '0;
      end else begin
        fcnt_d[i] = fcnt_q[i] + 1'b1;
      end
    end
  end

  assign scl_rise  = filt_q[0] & ~prev_q[0];
  assign scl_fall  = ~filt_q[0] & prev_q[0];
  assign start_det = filt_q[0] & prev_q[0] & ~filt_q[1] & prev_q[1];
  assign stop_det  = filt_q[0] & prev_q[0] & filt_q[1] & ~prev_q[1];

  always_comb begin
    case (state_q)
      ST_ADDR_ACK, ST_PTR_ACK, ST_DATA_ACK: want_drive = 1'b1;
      ST_RD_BYTE:                           want_drive = ~tx_q[7];
      default:                              want_drive = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    ptr_d     = ptr_q;
    snap_d    = snap_q;
    rw_d      = rw_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    sda_oe_d  = sda_oe_q;
`ifdef I2C_TARGET_CLK_STRETCH_EN
    scl_oe_d  = scl_oe_q;
    str_cnt_d = str_cnt_q;
`endif
    // sda only moves on the clock after the FSM has seen scl fall
    if (fall_dly_q) sda_oe_d = want_drive;
    if (scl_rise) rx_d = {rx_q[6:0], filt_q[1]};

    if (stop_det) begin
      state_d   = ST_IDLE;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
      done_d    = busy_q;
`ifdef I2C_TARGET_CLK_STRETCH_EN
      scl_oe_d  = 1'b0;
`endif
    end else if (start_det) begin
      state_d   = ST_ADDR;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
`ifdef I2C_TARGET_CLK_STRETCH_EN
      scl_oe_d  = 1'b0;
`endif
    end else begin
      case (state_q)
        ST_ADDR, ST_WR_PTR, ST_WR_DATA: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            bit_cnt_d = '0;
            if (state_q == ST_ADDR) begin
              if (rx_q[7:1] == DEV_ADDR) begin
                state_d = ST_ADDR_ACK;
                busy_d  = 1'b1;
                rw_d    = rx_q[0];
`ifndef I2C_TARGET_CLK_STRETCH_EN
                if (rx_q[0]) snap_d = angle;
`endif
              end else begin
                state_d = ST_WAIT_STOP;
              end
            end else if (state_q == ST_WR_PTR) begin
              ptr_d   = rx_q;
              state_d = ST_PTR_ACK;
            end else begin
              ptr_d   = ptr_q + 8'd1;
              state_d = ST_DATA_ACK;
            end
          end
        end
        ST_ADDR_ACK: begin
          if (scl_fall) begin
            bit_cnt_d = '0;
            if (rw_q) begin
`ifdef I2C_TARGET_CLK_STRETCH_EN
              state_d   = ST_STRETCH;
              scl_oe_d  = 1'b1;
              str_cnt_d = '0;
`else
              state_d = ST_RD_BYTE;
              tx_d    = reg_value(ptr_q, snap_q);
`endif
            end else begin
              state_d = ST_WR_PTR;
            end
          end
        end
        ST_PTR_ACK, ST_DATA_ACK: begin
          if (scl_fall) begin
            state_d   = ST_WR_DATA;
            bit_cnt_d = '0;
          end
        end
        ST_RD_BYTE: begin
          if (scl_fall) begin
            if (bit_cnt_q == 4'd7) begin
              state_d   = ST_RD_ACK;
              bit_cnt_d = '0;
            end else begin
              tx_d      = {tx_q[6:0], 1'b0};
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end
        ST_RD_ACK: begin
          // pointer advances past every byte read, including the NACKed last one
          if (scl_fall) begin
            ptr_d = ptr_q + 8'd1;
            if (!rx_q[0]) begin
              state_d = ST_RD_BYTE;
              tx_d    = reg_value(ptr_q + 8'd1, snap_q);
            end else begin
              state_d = ST_WAIT_STOP;
            end
          end
        end
`ifdef I2C_TARGET_CLK_STRETCH_EN
        ST_STRETCH: begin
          str_cnt_d = str_cnt_q + 1'b1;
          // snapshot and first bit are set up one clock before scl is let go
          if (str_cnt_q == SW'(STRETCH_CYCLES - 2)) begin
            snap_d   = angle;
            tx_d     = first_byte;
            sda_oe_d = ~first_byte[7];
          end
          if (str_cnt_q == SW'(STRETCH_CYCLES - 1)) begin
            scl_oe_d = 1'b0;
            state_d  = ST_RD_BYTE;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q    <= 2'b11;
      sync2_q    <= 2'b11;
      filt_q     <= 2'b11;
      prev_q     <= 2'b11;
      fcnt_q     <= '0;
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      rx_q       <= '0;
      tx_q       <= '0;
      ptr_q      <= '0;
      snap_q     <= '0;
      rw_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      sda_oe_q   <= 1'b0;
      fall_dly_q <= 1'b0;
`ifdef I2C_TARGET_CLK_STRETCH_EN
      scl_oe_q   <= 1'b0;
      str_cnt_q  <= '0;
`endif
    end else begin
      sync1_q    <= {sda_in, scl_in};
      sync2_q    <= sync1_q;
      filt_q     <= filt_d;
      prev_q     <= filt_q;
      fcnt_q     <= fcnt_d;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_q       <= rx_d;
      tx_q       <= tx_d;
      ptr_q      <= ptr_d;
      snap_q     <= snap_d;
      rw_q       <= rw_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      sda_oe_q   <= sda_oe_d;
      fall_dly_q <= scl_fall;
`ifdef I2C_TARGET_CLK_STRETCH_EN
      scl_oe_q   <= scl_oe_d;
      str_cnt_q  <= str_cnt_d;
`endif
    end
  end

  assign sda_oe    = sda_oe_q;
  assign busy      = busy_q;
  assign xfer_done = done_q;
  assign reg_ptr   = ptr_q;
`ifdef I2C_TARGET_CLK_STRETCH_EN
  assign scl_oe    = scl_oe_q;
`else
  assign scl_oe    = 1'b0;
`endif

endmodule
